// File: rtl/spi_bus_arbiter.sv
// Round-robin owner arbiter for a shared SPI core with chip-select sequencing and an ownership watchdog.
// Optional: define SPI_ARB_PRIO_EN to give requester 0 fixed highest priority in arbitration.
module spi_bus_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned NSS_NUM = 4,
   parameter int unsigned GAP_CYC = 4,
   parameter int unsigned TMO_W   = 16
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic [NUM_REQ-1:0]                   req_i,
   input  logic [NUM_REQ-1:0]                   rel_i,
   input  logic [NUM_REQ*$clog2(NSS_NUM)-1:0]   cs_map_i,
   input  logic [TMO_W-1:0]                     tmo_cfg_i,
   output logic [NUM_REQ-1:0]                   gnt_o,
   output logic [$clog2(NUM_REQ)-1:0]           owner_o,
   output logic                                 busy_o,
   output logic [NSS_NUM-1:0]                   nss_o,
   output logic                                 tmo_irq_o
);

   localparam int unsigned OW       = $clog2(NUM_REQ);
   localparam int unsigned CW       = $clog2(NSS_NUM);
   localparam int unsigned GAP_LAST = (GAP_CYC == 0) ? 0 : GAP_CYC - 1;
   localparam int unsigned GW       = (GAP_LAST < 2) ? 1 : $clog2(GAP_LAST + 1);

   typedef enum logic [1:0] {IDLE, SETUP, OWN, GAP} state_t;

   state_t               state_q, state_d;
   logic [OW-1:0]        owner_q, owner_d;
   logic [OW-1:0]        rr_q, rr_d;
   logic [CW-1:0]        cs_q, cs_d;
   logic [TMO_W-1:0]     tcnt_q, tcnt_d;
   logic [GW-1:0]        gcnt_q, gcnt_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [NSS_NUM-1:0]   nss_q, nss_d;
   logic                 irq_q, irq_d;
   logic                 busy_q, busy_d;

   logic [CW-1:0]        cs_map [NUM_REQ];
   logic [OW-1:0]        cand, win;
   logic                 found;

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_map
      assign cs_map[k] = cs_map_i[k*CW +: CW];
   end

   // Out-of-range indices match no bit, so no chip select is asserted.
   function automatic logic [NSS_NUM-1:0] cs_decode(input logic [CW-1:0] idx);
      logic [NSS_NUM-1:0] v;
      v = '1;
      for (int unsigned j = 0; j < NSS_NUM; j++) begin
         if (32'(idx) == j) v[j] = 1'b0;
      end
      return v;
   endfunction

   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         cand = OW'((32'(rr_q) + i) % NUM_REQ);
         if (!found && req_i[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
`ifdef SPI_ARB_PRIO_EN
      if (req_i[0]) begin
         found = 1'b1;
         win   = '0;
      end
`endif
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      cs_d    = cs_q;
      tcnt_d  = tcnt_q;
      gcnt_d  = gcnt_q;
      gnt_d   = '0;
      nss_d   = nss_q;
      irq_d   = 1'b0;
      case (state_q)
         IDLE: begin
            nss_d = '1;
            if (found) begin
               owner_d = win;
               cs_d    = cs_map[win];
               nss_d   = cs_decode(cs_map[win]);
`ifdef SPI_ARB_PRIO_EN
               if (!req_i[0]) rr_d = win;
`else
               rr_d    = win;
`endif
               state_d = SETUP;
            end
         end
         SETUP: begin
            gnt_d[owner_q] = 1'b1;
            tcnt_d         = '0;
            state_d        = OWN;
         end
         OWN: begin
            // Release/abandon is checked first so it wins over a coincident timeout.
            if (rel_i[owner_q] || !req_i[owner_q]) begin
               state_d = GAP;
               nss_d   = '1;
               gcnt_d  = '0;
            end else if ((tmo_cfg_i != '0) && (tcnt_q == tmo_cfg_i - TMO_W'(1))) begin
               state_d = GAP;
               nss_d   = '1;
               gcnt_d  = '0;
               irq_d   = 1'b1;
            end else begin
               gnt_d[owner_q] = 1'b1;
               if (tcnt_q != '1) tcnt_d = tcnt_q + TMO_W'(1);
            end
         end
         GAP: begin
            nss_d = '1;
            if (gcnt_q == GW'(GAP_LAST)) state_d = IDLE;
            else                         gcnt_d  = gcnt_q + GW'(1);
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         owner_q <= '0;
         rr_q    <= OW'(NUM_REQ - 1);
         cs_q    <= '0;
         tcnt_q  <= '0;
         gcnt_q  <= '0;
         gnt_q   <= '0;
         nss_q   <= '1;
         irq_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         cs_q    <= cs_d;
         tcnt_q  <= tcnt_d;
         gcnt_q  <= gcnt_d;
         gnt_q   <= gnt_d;
         nss_q   <= nss_d;
         irq_q   <= irq_d;
         busy_q  <= busy_d;
      end
   end

   assign gnt_o     = gnt_q;
   assign owner_o   = owner_q;
   assign busy_o    = busy_q;
   assign nss_o     = nss_q;
   assign tmo_irq_o = irq_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed self-checking bench for spi_bus_arbiter; a second instance covers GAP_CYC=0 and NSS_NUM=3.
module tb_spi_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req, rel;
   logic [7:0]  cs_map;
   logic [15:0] tmo;

   logic [3:0]  gnt, nss;
   logic [1:0]  owner;
   logic        busy, irq;

   logic [3:0]  gnt0;
   logic [2:0]  nss0;
   logic [1:0]  owner0;
   logic        busy0, irq0;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   always #5 clk = ~clk;

   spi_bus_arbiter #(.NUM_REQ(4), .NSS_NUM(4), .GAP_CYC(4), .TMO_W(16)) u_dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .rel_i(rel), .cs_map_i(cs_map),
      .tmo_cfg_i(tmo), .gnt_o(gnt), .owner_o(owner), .busy_o(busy),
      .nss_o(nss), .tmo_irq_o(irq)
   );

   spi_bus_arbiter #(.NUM_REQ(4), .NSS_NUM(3), .GAP_CYC(0), .TMO_W(16)) u_dut0 (
      .clk_i(clk), .rst_i(rst), .req_i(req), .rel_i(rel), .cs_map_i(cs_map),
      .tmo_cfg_i(tmo), .gnt_o(gnt0), .owner_o(owner0), .busy_o(busy0),
      .nss_o(nss0), .tmo_irq_o(irq0)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req = '0;
      rel = '0;
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
   endtask

   task automatic wait_gnt();
      for (int unsigned c = 0; c < 50; c++) begin
         if (gnt != '0) break;
         tick(1);
      end
   endtask

   int unsigned exp_order [5];

   initial begin
      rst = 1'b1; req = '0; rel = '0; cs_map = '0; tmo = '0;
      tick(2);
      check("rst_gnt",   32'(gnt),   32'h0);
      check("rst_owner", 32'(owner), 32'h0);
      check("rst_busy",  32'(busy),  32'h0);
      check("rst_nss",   32'(nss),   32'hf);
      check("rst_irq",   32'(irq),   32'h0);
      rst = 1'b0;

      // Single request, CS 3, release and 4-cycle gap
      cs_map = 8'h30;
      req = 4'b0100;
      tick(1);
      check("single_setup_gnt",   32'(gnt),   32'h0);
      check("single_setup_nss",   32'(nss),   32'h7);
      check("single_setup_owner", 32'(owner), 32'h2);
      check("single_setup_busy",  32'(busy),  32'h1);
      tick(1);
      check("single_own_gnt", 32'(gnt), 32'h4);
      check("single_own_nss", 32'(nss), 32'h7);
      req = 4'b0000;
      rel = 4'b0100;
      tick(1);
      rel = 4'b0000;
      check("single_gap_gnt", 32'(gnt), 32'h0);
      check("single_gap_nss", 32'(nss), 32'hf);
      for (int unsigned g = 0; g < 3; g++) begin
         check("single_gap_busy", 32'(busy), 32'h1);
         tick(1);
      end
      check("single_gap_busy_last", 32'(busy), 32'h1);
      check("single_gap_nss_last",  32'(nss),  32'hf);
      tick(1);
      check("single_idle_busy", 32'(busy), 32'h0);

      // Fairness with all requesters held
      do_reset();
`ifdef SPI_ARB_PRIO_EN
      exp_order = '{0, 0, 0, 0, 0};
`else
      exp_order = '{0, 1, 2, 3, 0};
`endif
      req = 4'b1111;
      for (int unsigned k = 0; k < 5; k++) begin
         wait_gnt();
         check("fair_gnt", 32'(gnt), 32'(4'b0001 << exp_order[k]));
         tick(2);
         rel = gnt;
         tick(1);
         rel = '0;
      end
      req = '0;
      tick(6);

      // Watchdog reclaim after exactly 10 OWN cycles
      do_reset();
      tmo = 16'd10;
      req = 4'b0010;
      tick(2);
      check("wd_first_gnt", 32'(gnt), 32'h2);
      req = 4'b0011;
      for (int unsigned c = 0; c < 9; c++) begin
         tick(1);
         check("wd_hold_gnt", 32'(gnt), 32'h2);
      end
      tick(1);
      check("wd_drop_gnt", 32'(gnt), 32'h0);
      check("wd_irq",      32'(irq), 32'h1);
      tmo = 16'd0;
      tick(1);
      check("wd_irq_pulse", 32'(irq), 32'h0);
      tick(3);
      check("wd_gap_end_busy", 32'(busy), 32'h0);
      tick(2);
      check("wd_next_gnt", 32'(gnt), 32'h1);

      // Watchdog disabled: grant holds
      tick(1000);
      check("wd_off_gnt", 32'(gnt), 32'h1);
      check("wd_off_irq", 32'(irq), 32'h0);
      req = '0;
      tick(6);

      // Release in the same cycle the counter reaches tmo-1
      do_reset();
      tmo = 16'd10;
      req = 4'b0100;
      tick(2);
      check("coin_gnt", 32'(gnt), 32'h4);
      tick(9);
      check("coin_pre_gnt", 32'(gnt), 32'h4);
      req = 4'b0000;
      rel = 4'b0100;
      tick(1);
      rel = '0;
      check("coin_rel_gnt", 32'(gnt), 32'h0);
      check("coin_rel_irq", 32'(irq), 32'h0);
      tick(1);
      check("coin_rel_irq2", 32'(irq), 32'h0);
      tmo = '0;
      tick(6);

      // Asynchronous reset while owning
      do_reset();
      req = 4'b0010;
      tick(2);
      check("arst_pre_gnt", 32'(gnt), 32'h2);
      #2;
      rst = 1'b1;
      #1;
      check("arst_gnt",  32'(gnt),  32'h0);
      check("arst_nss",  32'(nss),  32'hf);
      check("arst_busy", 32'(busy), 32'h0);
      rst = 1'b0;
      req = 4'b0011;
      tick(2);
      check("arst_next_gnt", 32'(gnt), 32'h1);
      req = '0;
      tick(6);

      // Non-owner release ignored; abandon; 1-cycle gap; out-of-range CS
      do_reset();
      cs_map = 8'hc0;
      req = 4'b0010;
      tick(2);
      check("nonown_gnt",  32'(gnt),  32'h2);
      check("nonown_gnt0", 32'(gnt0), 32'h2);
      rel = 4'b1000;
      tick(1);
      rel = '0;
      check("nonown_hold",  32'(gnt),  32'h2);
      check("nonown_hold0", 32'(gnt0), 32'h2);
      req = 4'b1000;
      tick(1);
      check("abandon_gnt0",  32'(gnt0),  32'h0);
      check("abandon_nss0",  32'(nss0),  32'h7);
      check("abandon_busy0", 32'(busy0), 32'h1);
      check("abandon_irq0",  32'(irq0),  32'h0);
      tick(1);
      check("gap0_idle_busy0", 32'(busy0), 32'h0);
      check("gap4_busy",       32'(busy),  32'h1);
      tick(1);
      check("oor_setup_nss0",   32'(nss0),   32'h7);
      check("oor_setup_owner0", 32'(owner0), 32'h3);
      tick(1);
      check("oor_own_gnt0", 32'(gnt0), 32'h8);
      check("oor_own_nss0", 32'(nss0), 32'h7);
      req = '0;
      tick(6);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Round-robin arbiter that shares one SPI core (and its 4 chip-select lines) between up to NUM_REQ on-chip requesters, e.g. the CPU APB path, a flash XIP engine and a DMA engine.
- Sits between the requesters and the SPI core's register/pin layer.
- Owns chip-select sequencing: setup delay, hold until release, minimum deselect gap between owners.
- Provides a watchdog that reclaims the bus from a stuck owner.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
NSS_NUM, 4, number of active-low chip selects driven
GAP_CYC, 4, minimum idle cycles with all CS high between two grants (0 allowed)
TMO_W, 16, width of the ownership-timeout counter

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous reset, active-high
req_i  input  NUM_REQ  per-requester bus request, level; held until granted
rel_i  input  NUM_REQ  per-requester release pulse; only the owner's bit is honoured
cs_map_i  input  NUM_REQ*$clog2(NSS_NUM)  CS index per requester; field k = requester k
tmo_cfg_i  input  TMO_W  ownership timeout in cycles; 0 = watchdog disabled
gnt_o  output  NUM_REQ  one-hot grant, zero or one bit set
owner_o  output  $clog2(NUM_REQ)  index of current/last owner
busy_o  output  1  high in any state other than IDLE
nss_o  output  NSS_NUM  active-low chip selects toward the pads
tmo_irq_o  output  1  one-cycle pulse when the watchdog reclaims the bus

Behaviour:
- Reset values: gnt_o=0, owner_o=0, busy_o=0, nss_o=all 1, tmo_irq_o=0, state=IDLE, rr_ptr=NUM_REQ-1, counters=0.
- Reset asserted mid-transfer returns to these values immediately (asynchronous). No gap is enforced after reset.
- Clock and reset inputs are named clk_i and rst_i. There is one clock. Reset is asynchronous and active-high.
- FSM states are IDLE, SETUP, OWN and GAP. All outputs are registered.
- IDLE:
  - If any req_i bit is set, pick the first set bit scanning rr_ptr+1, rr_ptr+2, ... with wrap modulo NUM_REQ.
  - Latch the winner into owner_o and the latched CS index (cs_map_i sampled at this edge), set rr_ptr=winner, go to SETUP.
  - No request: stay in IDLE.
- SETUP (1 cycle): nss_o[cs_idx]=0, all other nss_o bits 1, gnt_o=0. Then go to OWN.
- OWN: gnt_o[owner]=1 and nss_o is unchanged. Grant latency from req_i rise in IDLE is 2 cycles. Exit to GAP when any of the following occurs:
  - rel_i[owner]=1.
  - req_i[owner] drops (abandon).
  - Watchdog: the cycle counter (cleared on entry, saturating) reaches tmo_cfg_i-1 with tmo_cfg_i!=0. tmo_irq_o pulses on the cycle GAP is entered.
  - If release and timeout coincide, release wins and there is no irq.
- OWN other rules: rel_i bits of non-owners are ignored. Changes to cs_map_i while owning have no effect.
- GAP: gnt_o=0, nss_o=all 1. Stay GAP_CYC cycles (counter 0..GAP_CYC-1), then go to IDLE. GAP_CYC=0 means GAP lasts exactly 1 cycle.
- Requests arriving during SETUP/OWN/GAP wait; arbitration happens only in IDLE.
- A requester that keeps req_i high after release competes again, but round-robin places it last.
- An out-of-range cs_map field (>= NSS_NUM) asserts no CS. The grant still proceeds.

Optional Feature:
SPI_ARB_PRIO_EN:
- Defined: requester 0 has fixed highest priority. If req_i[0] is set in IDLE it wins regardless of rr_ptr, and rr_ptr is not updated on its grant. There is no preemption of an existing owner.
- Undefined: pure round-robin as above.

Test Plan:
- Single request: req_i=4'b0100 with cs_map field2=3 -> gnt_o=4'b0100 two cycles later; nss_o=4'b0111 from SETUP; rel_i[2] pulse -> gnt_o=0 and nss_o=4'b1111 for 4 cycles; busy_o falls in the cycle IDLE is entered.
- Fairness: req_i=4'b1111 held, each owner releases after 3 cycles -> grant order 0,1,2,3,0. With SPI_ARB_PRIO_EN the order is 0,0,0...
- Watchdog: tmo_cfg_i=10, owner never releases -> gnt_o drops after exactly 10 OWN cycles; tmo_irq_o pulses 1 cycle; next requester is granted after the gap. With tmo_cfg_i=0 the grant holds 1000 cycles.
- Coincident release and timeout: rel_i in the same cycle the counter hits 9 with tmo_cfg_i=10 -> normal release, tmo_irq_o stays 0.
- Reset mid-OWN: assert rst_i while gnt_o=4'b0010 -> gnt_o=0, nss_o=4'b1111 without a clock edge. After release with req_i=4'b0011, requester 0 is granted first (rr_ptr=3).
- Non-owner release and abandon: rel_i[3] pulsed while 1 owns -> no effect; owner drops req_i -> GAP, next grant after GAP_CYC=0 gives a 1-cycle gap.
